// File: rtl/sr_flag_arbiter_if.sv
// sr_flag_arbiter_if: request/grant bundle between flag-updating agents and the arbiter
interface sr_flag_arbiter_if #(
    parameter int NREQ  = 4,
    parameter int NFLAG = 8
);
    localparam int AW = $clog2(NFLAG);
    logic [NREQ-1:0]    req_valid;
    logic [NREQ-1:0]    req_op;
    logic [NREQ*AW-1:0] req_idx;
    logic [NREQ-1:0]    req_ready;
    modport master (output req_valid, req_op, req_idx, input req_ready);
    modport slave  (input req_valid, req_op, req_idx, output req_ready);
endinterface

// File: rtl/sr_flag_arbiter.sv
// sr_flag_arbiter: round-robin arbitrated set/clear flag bank, one update per cycle
// Optional redundant-update counter enabled by SR_ARB_REDUND_CNT_EN
module sr_flag_arbiter #(
    parameter int NREQ  = 4,
    parameter int NFLAG = 8,
    localparam int AW   = $clog2(NFLAG),
    localparam int IW   = $clog2(NREQ)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    sr_flag_arbiter_if.slave     req,
    input  logic                 clr_all,
    output logic [NFLAG-1:0]     flags,
    output logic                 ack_valid,
    output logic [IW-1:0]        ack_id,
    output logic [7:0]           redund_cnt
);
    logic [IW-1:0] rr_ptr, gnt, cand;
    logic [AW-1:0] g_idx;
    logic          found, grant, g_op, in_range;

    // descending scan so the candidate closest to rr_ptr wins
    always_comb begin
        gnt   = '0;
        cand  = '0;
        found = 1'b0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            cand = IW'((int'(rr_ptr) + k) % NREQ);
            if (req.req_valid[cand]) begin
                gnt   = cand;
                found = 1'b1;
            end
        end
    end

    always_comb begin
        g_idx = '0;
        for (int k = 0; k < NREQ; k++)
            if (IW'(k) == gnt) g_idx = req.req_idx[k*AW +: AW];
    end

    assign g_op          = req.req_op[gnt];
    assign grant         = found && rst_n && !clr_all;
    assign in_range      = int'(g_idx) < NFLAG;
    assign req.req_ready = grant ? NREQ'(1) << gnt : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flags     <= '0;
            rr_ptr    <= '0;
            ack_valid <= 1'b0;
            ack_id    <= '0;
        end else begin
            ack_valid <= grant;
            if (grant) begin
                ack_id <= gnt;
                rr_ptr <= IW'((int'(gnt) + 1) % NREQ);
                if (in_range) flags[g_idx] <= g_op;
            end
            if (clr_all) flags <= '0;
        end
    end

`ifdef SR_ARB_REDUND_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) redund_cnt <= '0;
        else if (grant && in_range && flags[g_idx] == g_op && redund_cnt != 8'hFF)
            redund_cnt <= redund_cnt + 8'd1;
    end
`else
    assign redund_cnt = '0;
`endif
endmodule

// File: doc/sr_flag_arbiter.md
# sr_flag_arbiter

Shared bank of NFLAG set/reset flags with one registered update per cycle, arbitrated round-robin among NREQ requesters. Each request is a set or a clear of a single indexed flag. This turns the latch-style set/reset resource into a clocked, conflict-free shared structure. Simultaneous set and clear of the same bit cannot occur. Sits between the control agents that raise or drop status flags and the logic that reads the flag vector.

## Interface
- NREQ, 4, number of requesters (2..8)
- NFLAG, 8, number of flags in the bank (2..256)
- AW, $clog2(NFLAG), flag index width
- IW, $clog2(NREQ), requester id width
- clk  in  1  clock; all state updates on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- req_valid  in  NREQ  request pending, one bit per requester
- req_op  in  NREQ  per requester: 1 = set, 0 = clear
- req_idx  in  NREQ*AW  per requester flag index; requester i uses bits [i*AW +: AW]
- req_ready  out  NREQ  one-hot grant, combinational; at most one bit high
- clr_all  in  1  synchronous clear of the whole bank
- flags  out  NFLAG  registered flag bank
- ack_valid  out  1  registered pulse, one cycle after a grant
- ack_id  out  IW  requester id of the acknowledged grant
- redund_cnt  out  8  redundant-request counter (see Configuration)

## Operation
- Handshake:
  - A request transfers when req_valid[i] && req_ready[i].
  - A requester holds valid, op and idx stable until it is granted.
  - Dropping valid before grant is allowed; that request is discarded.
- Arbitration:
  - rr_ptr (IW bits) marks the highest-priority requester.
  - Search order is rr_ptr, rr_ptr+1, … mod NREQ.
  - The first valid requester in that order is granted.
  - After a grant to requester g, rr_ptr <= (g+1) mod NREQ.
  - With no grant, rr_ptr is unchanged.
- Flag update on a grant to g:
  - set: flags[idx] <= 1.
  - clear: flags[idx] <= 0.
  - All other bits hold.
- Out-of-range index (idx >= NFLAG when NFLAG is not a power of two):
  - The request is still granted and acknowledged.
  - The bank is unchanged.
- clr_all = 1:
  - req_ready = 0 for that cycle, so no grant is made.
  - flags <= 0 and rr_ptr holds.
  - clr_all overrides any pending request.
- ack_valid/ack_id: ack_valid <= |req_ready; ack_id <= the granted id.
- Reset values: flags = 0, rr_ptr = 0, ack_valid = 0, ack_id = 0, redund_cnt = 0.
- Reset mid-operation:
  - Reset asserted: all state returns to reset values immediately.
  - An in-flight grant is lost and produces no ack.
  - req_ready is 0 while rst_n = 0.

## Timing
- Grant is combinational in the same cycle as req_valid.
- Flag change is visible on flags the cycle after the grant (latency 1).
- ack_valid is coincident with that flag change.
- Throughput is one update per cycle.
- With all NREQ requesters continuously valid, each is granted exactly once in every NREQ consecutive cycles.
- No combinational path from req_* to flags or ack_*.

## Configuration
- SR_ARB_REDUND_CNT_EN defined:
  - Counts redundant grants: a set of an already-set flag, or a clear of an already-clear flag.
  - The comparison uses the flag value before the update.
  - redund_cnt increments the cycle after such a grant and saturates at 255.
  - clr_all does not reset the counter; only rst_n does.
- SR_ARB_REDUND_CNT_EN undefined:
  - No counter logic.
  - redund_cnt is tied to 0.

## Test plan
- Reset:
  - Drive rst_n = 0 with req_valid = 4'hF.
  - Required: req_ready = 0, flags = 8'h00, ack_valid = 0.
- Single set then clear:
  - Req 2 sets idx 5 at cycle t, then req 2 clears idx 5 at cycle t+1.
  - Required: flags = 8'h20 at t+1 and 8'h00 at t+2.
  - Required: ack_id = 2 on both cycles.
- Round-robin fairness:
  - All four requesters valid for 8 cycles, each setting its own idx 0..3.
  - Required grant order: 0,1,2,3,0,1,2,3.
  - Required: flags = 8'h0F after the first four acks.
- Contention on the same bit:
  - Req 0 sets idx 7 and req 1 clears idx 7, both valid from reset.
  - Required: req 0 granted first, then req 1.
  - Required: flags[7] = 1, then 0.
- clr_all collision:
  - flags = 8'hFF and req 3 valid (set idx 0) in the same cycle as clr_all.
  - Required: req_ready = 0 and flags = 8'h00 next cycle.
  - Required: req 3 is granted the following cycle, giving flags = 8'h01.
- Redundant counter (macro defined):
  - Set idx 1 three times.
  - Required: redund_cnt = 2.
  - Required: after 300 redundant sets, redund_cnt = 255.
  - Without the macro, redund_cnt stays 0.
